// File: rtl/conv_1_post_process_if.sv
// BRAM-side bus bundle for conv_1_post_process: conv-output read port,
// bias read port and next-layer write port, all sharing one clock.
interface conv_1_post_process_if #(
    parameter int AXI_HP_BIT = 64,
    parameter int ADDR_WIDTH = 14
);
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [AXI_HP_BIT-1:0] rd_data;

    logic                  bias_rd_en;
    logic [ADDR_WIDTH-1:0] bias_rd_addr;
    logic [AXI_HP_BIT-1:0] bias_rd_data;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [AXI_HP_BIT-1:0] wr_data;

    modport master (
        output rd_en, rd_addr,
        input  rd_data,
        output bias_rd_en, bias_rd_addr,
        input  bias_rd_data,
        output wr_en, wr_addr, wr_data
    );

    modport slave (
        input  rd_en, rd_addr,
        output rd_data,
        input  bias_rd_en, bias_rd_addr,
        output bias_rd_data,
        input  wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/conv_1_post_process.sv
// Walks the packed conv-output BRAM channel by channel, applying bias, arithmetic
// shift, optional ReLU and saturation per 16-bit lane, and writes the next-layer BRAM.
module conv_1_post_process #(
    parameter int AXI_HP_BIT = 64,
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sudo_reset,
    input  logic        post_en,
    output logic        post_done,
    input  logic [9:0]  in_row,
    input  logic [9:0]  in_column,
    input  logic [11:0] output_channel,
    input  logic [3:0]  shift,
    input  logic        relu_en,
    conv_1_post_process_if.master bram
);
    localparam int LANES = AXI_HP_BIT / DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIAS_RD,
        S_BIAS_CAP,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  state_reg, state_next;
    logic [11:0]             ch_reg, ch_next;
    logic [ADDR_WIDTH-1:0]   base_reg, base_next;
    logic [ADDR_WIDTH-1:0]   idx_reg, idx_next;
    logic                    drain_reg, drain_next;
    logic [ADDR_WIDTH-1:0]   w_reg, w_next;
    logic [11:0]             oc_reg, oc_next;
    logic [3:0]              shift_reg, shift_next;
    logic                    relu_reg, relu_next;
    logic [DATA_WIDTH-1:0]   bias_reg, bias_next;

    logic                    rd_en_reg, rd_en_next;
    logic [ADDR_WIDTH-1:0]   rd_addr_reg, rd_addr_next;
    logic                    bias_rd_en_reg, bias_rd_en_next;
    logic [ADDR_WIDTH-1:0]   bias_rd_addr_reg, bias_rd_addr_next;
    logic                    post_done_reg, post_done_next;

    // Compute pipeline: pend_* tracks the read whose data is on rd_data this cycle.
    logic                    pend_valid_reg;
    logic [ADDR_WIDTH-1:0]   pend_addr_reg;
    logic                    wr_en_reg;
    logic [ADDR_WIDTH-1:0]   wr_addr_reg;
    logic [AXI_HP_BIT-1:0]   wr_data_reg, wr_data_next;

    logic [ADDR_WIDTH-1:0]   words_per_ch;
    logic [DATA_WIDTH-1:0]   rd_lane   [LANES];
    logic [DATA_WIDTH-1:0]   bias_lane [LANES];

    assign words_per_ch = ADDR_WIDTH'(({10'd0, in_row} * {10'd0, in_column}) >> 2);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [DATA_WIDTH:0] sum_s;
            logic signed [DATA_WIDTH:0] shr_s;
            logic [DATA_WIDTH-1:0]      res;

            assign rd_lane[gi]   = bram.rd_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign bias_lane[gi] = bram.bias_rd_data[gi*DATA_WIDTH +: DATA_WIDTH];

            // One extra bit keeps the bias add exact; overflow shows up as bit mismatch after shift.
            assign sum_s = $signed({rd_lane[gi][DATA_WIDTH-1], rd_lane[gi]})
                         + $signed({bias_reg[DATA_WIDTH-1], bias_reg});
            assign shr_s = sum_s >>> shift_reg;

            always_comb begin
                res = shr_s[DATA_WIDTH-1:0];
                if (relu_reg && shr_s[DATA_WIDTH]) begin
                    res = '0;
                end else if (shr_s[DATA_WIDTH] != shr_s[DATA_WIDTH-1]) begin
                    res = shr_s[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                            : {1'b0, {(DATA_WIDTH-1){1'b1}}};
                end
            end

            assign wr_data_next[gi*DATA_WIDTH +: DATA_WIDTH] = res;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        ch_next    = ch_reg;
        base_next  = base_reg;
        idx_next   = idx_reg;
        drain_next = drain_reg;
        w_next     = w_reg;
        oc_next    = oc_reg;
        shift_next = shift_reg;
        relu_next  = relu_reg;
        bias_next  = bias_reg;

        case (state_reg)
            S_IDLE: begin
                if (post_en) begin
                    state_next = S_BIAS_RD;
                    ch_next    = '0;
                    base_next  = '0;
                    idx_next   = '0;
                    drain_next = 1'b0;
                    w_next     = words_per_ch;
                    oc_next    = output_channel;
                    shift_next = shift;
                    relu_next  = relu_en;
                end
            end
            S_BIAS_RD: begin
                state_next = S_BIAS_CAP;
            end
            S_BIAS_CAP: begin
                bias_next  = bias_lane[ch_reg[1:0]];
                idx_next   = '0;
                state_next = S_STREAM;
            end
            S_STREAM: begin
                if (idx_reg == w_reg - 1'b1) begin
                    state_next = S_DRAIN;
                    drain_next = 1'b0;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            S_DRAIN: begin
                // Two drain cycles let the last word of this channel clear the compute
                // stage before the next channel's bias is captured.
                if (drain_reg) begin
                    if (ch_reg != oc_reg - 12'd1) begin
                        state_next = S_BIAS_RD;
                        ch_next    = ch_reg + 12'd1;
                        base_next  = base_reg + w_reg;
                    end else begin
                        state_next = S_DONE;
                    end
                end else begin
                    drain_next = 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        rd_en_next        = (state_next == S_STREAM);
        rd_addr_next      = rd_en_next ? (base_next + idx_next) : '0;
        bias_rd_en_next   = (state_next == S_BIAS_RD);
        bias_rd_addr_next = bias_rd_en_next ? ADDR_WIDTH'(ch_next >> 2) : '0;
        post_done_next    = (state_next == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= S_IDLE;
            ch_reg           <= '0;
            base_reg         <= '0;
            idx_reg          <= '0;
            drain_reg        <= 1'b0;
            w_reg            <= '0;
            oc_reg           <= '0;
            shift_reg        <= '0;
            relu_reg         <= 1'b0;
            bias_reg         <= '0;
            rd_en_reg        <= 1'b0;
            rd_addr_reg      <= '0;
            bias_rd_en_reg   <= 1'b0;
            bias_rd_addr_reg <= '0;
            post_done_reg    <= 1'b0;
            pend_valid_reg   <= 1'b0;
            pend_addr_reg    <= '0;
            wr_en_reg        <= 1'b0;
            wr_addr_reg      <= '0;
            wr_data_reg      <= '0;
        end else if (sudo_reset) begin
            state_reg        <= S_IDLE;
            ch_reg           <= '0;
            base_reg         <= '0;
            idx_reg          <= '0;
            drain_reg        <= 1'b0;
            w_reg            <= '0;
            oc_reg           <= '0;
            shift_reg        <= '0;
            relu_reg         <= 1'b0;
            bias_reg         <= '0;
            rd_en_reg        <= 1'b0;
            rd_addr_reg      <= '0;
            bias_rd_en_reg   <= 1'b0;
            bias_rd_addr_reg <= '0;
            post_done_reg    <= 1'b0;
            pend_valid_reg   <= 1'b0;
            pend_addr_reg    <= '0;
            wr_en_reg        <= 1'b0;
            wr_addr_reg      <= '0;
            wr_data_reg      <= '0;
        end else begin
            state_reg        <= state_next;
            ch_reg           <= ch_next;
            base_reg         <= base_next;
            idx_reg          <= idx_next;
            drain_reg        <= drain_next;
            w_reg            <= w_next;
            oc_reg           <= oc_next;
            shift_reg        <= shift_next;
            relu_reg         <= relu_next;
            bias_reg         <= bias_next;
            rd_en_reg        <= rd_en_next;
            rd_addr_reg      <= rd_addr_next;
            bias_rd_en_reg   <= bias_rd_en_next;
            bias_rd_addr_reg <= bias_rd_addr_next;
            post_done_reg    <= post_done_next;
            pend_valid_reg   <= rd_en_reg;
            pend_addr_reg    <= rd_addr_reg;
            wr_en_reg        <= pend_valid_reg;
            wr_addr_reg      <= pend_valid_reg ? pend_addr_reg : '0;
            wr_data_reg      <= pend_valid_reg ? wr_data_next : '0;
        end
    end

    assign post_done         = post_done_reg;
    assign bram.rd_en        = rd_en_reg;
    assign bram.rd_addr      = rd_addr_reg;
    assign bram.bias_rd_en   = bias_rd_en_reg;
    assign bram.bias_rd_addr = bias_rd_addr_reg;
    assign bram.wr_en        = wr_en_reg;
    assign bram.wr_addr      = wr_addr_reg;
    assign bram.wr_data      = wr_data_reg;
endmodule

// File: doc/conv_1_post_process.md
# conv_1_post_process

Post-processing stage directly downstream of the 1x1 convolution engine. Once the convolution block has filled the output BRAM with packed 16-bit partial results (4 pixels per 64-bit word, channel-major), this block walks that BRAM channel by channel, adds a per-output-channel bias, applies an arithmetic right shift, optional ReLU and 16-bit saturation, and writes the results into the next layer's input BRAM in the identical packed layout.

## Interface
Parameters:
- AXI_HP_BIT, 64, BRAM word width; 4 lanes of 16 bits
- ADDR_WIDTH, 14, BRAM address width
- DATA_WIDTH, 16, lane width

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  asynchronous, active-low; one clock domain only
- sudo_reset  in  1  synchronous soft reset, active-high; same effect as reset on the next edge
- post_en  in  1  start request, sampled only in IDLE
- post_done  out  1  high for exactly the one DONE cycle
- in_row, in_column  in  10 each  feature-map size; in_row*in_column must be a nonzero multiple of 4
- output_channel  in  12  number of output channels, at least 1
- shift  in  4  arithmetic right-shift amount, 0-15
- relu_en  in  1  1 = clamp negatives to 0
- rd_en / rd_addr / rd_data  out/out/in  1 / ADDR_WIDTH / AXI_HP_BIT  conv output BRAM read port, 1-cycle read latency
- bias_rd_en / bias_rd_addr / bias_rd_data  out/out/in  1 / ADDR_WIDTH / AXI_HP_BIT  bias BRAM, 4 signed 16-bit biases per word; channel c is at word c>>2, lane c&3 (lane 0 = bits 15:0); 1-cycle latency
- wr_en / wr_addr / wr_data  out/out/out  1 / ADDR_WIDTH / AXI_HP_BIT  next-layer input BRAM write port

## Operation
- W = in_row*in_column/4 words per channel. Channel c, word i is at address c*W+i, for both read and write.
- On the IDLE->BIAS_RD transition, in_row, in_column, output_channel, shift and relu_en are latched. Input changes during a run are ignored. post_en is ignored while busy.
- States and transitions:
  - IDLE -> BIAS_RD when post_en = 1.
  - BIAS_RD: bias_rd_en=1, bias_rd_addr=ch>>2.
  - BIAS_CAP: capture lane ch&3 of bias_rd_data into bias_reg.
  - STREAM: W cycles with rd_en=1 and rd_addr=base+i, where i counts 0..W-1.
  - DRAIN: 2 cycles, flushes the pipeline.
  - After DRAIN: go to BIAS_RD with ch+1 and base+W if ch < output_channel-1, else go to DONE.
  - DONE -> IDLE.
- Per-lane arithmetic on signed values:
  - s = sext17(x) + sext17(bias_reg), held exact in 17 bits.
  - t = s >>> shift (arithmetic).
  - If relu_en and t < 0, then t = 0.
  - Saturate t to [-32768, 32767].
  - Lane order is preserved in wr_data.
- The bias register only changes in BIAS_CAP. DRAIN guarantees no in-flight word of channel c is computed with the bias of channel c+1.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
  - reset takes effect immediately (asynchronous).
  - sudo_reset takes effect at the next edge. Both abort any run with no partial-done pulse.
- Read-to-write latency is 2 cycles: rd_en at cycle t, rd_data valid at t+1 and registered through the compute stage, wr_en/wr_addr/wr_data valid at t+2.
- Outputs are all registered; wr_en never asserts outside STREAM+2 windows.
- Each channel takes W+4 cycles. post_done asserts in cycle output_channel*(W+4)+1 after the edge that samples post_en.
- Back-to-back: post_en held high in the cycle after DONE starts a new run immediately (IDLE lasts 1 cycle).
- W=1 is legal: STREAM lasts a single cycle.

## Test plan
- Basic lane check:
  - Setup: in_row=4, in_column=4 (W=4), output_channel=1, bias=100, shift=0, relu_en=0.
  - Stimulus: word 0 lanes {1, -2, 32767, -32768}.
  - Required: wr_data lanes {101, 98, 32767 (sat), -32668}; wr_addr sequence 0..3; wr_en exactly 2 cycles after each rd_en.
- Shift and ReLU:
  - Stimulus: bias=24, shift=4, lanes {1000, -1048, 8, -8}.
  - With relu_en=0: {64, -64, 2, 1}.
  - With relu_en=1: {64, 0, 2, 1}.
- Bias lane select:
  - Setup: output_channel=5, W=1, bias words {10,20,30,40}, {50,...}, all data lanes 0.
  - Required: bias_rd_addr sequence 0,0,0,0,1; outputs at addresses 0..4 are all-lanes {10,20,30,40,50}.
- Cycle count:
  - Setup: in_row=2, in_column=2, output_channel=2.
  - Required: post_done high only in cycle 11 after post_en is sampled; exactly 2 writes occur.
- Reset mid-run:
  - Stimulus: assert reset low during STREAM of channel 1.
  - Required: all outputs go to 0 immediately, post_done never pulses.
  - Repeat with sudo_reset: outputs are 0 at the next edge.
  - In both cases a fresh post_en then completes a full correct run.
